// File: rtl/array_req_sequencer.sv
// Request sequencer for a single-port array: zero-latency issue, one-cycle array read,
// credit-controlled read-response FIFO. Define ARRAY_SEQ_PERF_EN to build the event counters.
module array_req_sequencer #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 128,
   parameter int RESP_DEPTH = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W/8-1:0]   req_wmask,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  RW0_en,
   output logic                  RW0_wmode,
   output logic [ADDR_W-1:0]     RW0_addr,
   output logic [DATA_W/8-1:0]   RW0_wmask,
   output logic [DATA_W-1:0]     RW0_wdata,
   input  logic [DATA_W-1:0]     RW0_rdata,
   output logic [31:0]           perf_reads,
   output logic [31:0]           perf_writes,
   output logic [31:0]           perf_stalls
);

   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_DEPTH - 1);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RESP_DEPTH);

   logic [CNT_W-1:0]  r_count;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic              r_rd_inflight;
   logic [DATA_W-1:0] r_mem [RESP_DEPTH];

   logic [CNT_W:0]    w_used;
   logic              w_credit;
   logic              w_accept;
   logic              w_accept_rd;
   logic              w_push;
   logic              w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   // An in-flight read already owns a FIFO slot, so it is counted against the credit.
   assign w_used      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rd_inflight};
   assign w_credit    = (w_used < DEPTH_C);
   assign req_ready   = reset_n & (req_write | w_credit);
   assign w_accept    = req_valid & req_ready & reset_n;
   assign w_accept_rd = w_accept & ~req_write;
   assign w_push      = r_rd_inflight;
   assign w_pop       = resp_ready & resp_valid;

   assign RW0_en      = w_accept;
   assign RW0_wmode   = req_write;
   assign RW0_addr    = req_addr;
   assign RW0_wmask   = req_wmask;
   assign RW0_wdata   = req_wdata;

   assign resp_valid  = (r_count != {CNT_W{1'b0}});
   assign resp_rdata  = r_mem[r_rd_ptr];

   // FIFO control state and read-in-flight tracking
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_count       <= {CNT_W{1'b0}};
         r_wr_ptr      <= {PTR_W{1'b0}};
         r_rd_ptr      <= {PTR_W{1'b0}};
         r_rd_inflight <= 1'b0;
      end else begin
         r_rd_inflight <= w_accept_rd;
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Response storage: captures array data only on the cycle after a read issue
   always_ff @(posedge clock) begin
      if (w_push && reset_n) r_mem[r_wr_ptr] <= RW0_rdata;
   end

`ifdef ARRAY_SEQ_PERF_EN
   logic [31:0] r_perf_reads;
   logic [31:0] r_perf_writes;
   logic [31:0] r_perf_stalls;

   // Event counters, free-running modulo 2^32
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_perf_reads  <= 32'd0;
         r_perf_writes <= 32'd0;
         r_perf_stalls <= 32'd0;
      end else begin
         if (w_accept_rd)              r_perf_reads  <= r_perf_reads + 32'd1;
         if (w_accept & req_write)     r_perf_writes <= r_perf_writes + 32'd1;
         if (req_valid & ~req_ready)   r_perf_stalls <= r_perf_stalls + 32'd1;
      end
   end

   assign perf_reads  = r_perf_reads;
   assign perf_writes = r_perf_writes;
   assign perf_stalls = r_perf_stalls;
`else
   assign perf_reads  = 32'd0;
   assign perf_writes = 32'd0;
   assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_array_req_sequencer.sv
// Self-checking bench: array model, transaction-level response model, directed and random stimulus.
module tb_array_req_sequencer;
   localparam int AW = 12;
   localparam int DW = 128;
   localparam int MW = DW / 8;
   localparam int DEPTH = 3;

   logic          clock;
   logic          reset_n;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [MW-1:0] req_wmask;
   logic [DW-1:0] req_wdata;
   logic          resp_valid, resp_ready;
   logic [DW-1:0] resp_rdata;
   logic          RW0_en, RW0_wmode;
   logic [AW-1:0] RW0_addr;
   logic [MW-1:0] RW0_wmask;
   logic [DW-1:0] RW0_wdata, RW0_rdata;
   logic [31:0]   perf_reads, perf_writes, perf_stalls;

   array_req_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
      .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata),
      .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_resp = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            avail;
   } ent_t;

   ent_t          exp_q[$];
   logic [DW-1:0] shadow  [0:4095];
   logic [DW-1:0] env_mem [0:4095];
   int            m_reads, m_writes, m_stalls;
   logic          exp_ready, exp_valid;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [MW-1:0] m);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Array model: one-cycle read latency, random junk on every other cycle
   always @(posedge clock) begin
      if (RW0_en && !RW0_wmode) RW0_rdata <= env_mem[RW0_addr];
      else                      RW0_rdata <= {$urandom, $urandom, $urandom, $urandom};
      if (RW0_en && RW0_wmode)  env_mem[RW0_addr] <= merge(env_mem[RW0_addr], RW0_wdata, RW0_wmask);
   end

   // Reference model and per-cycle comparison
   always @(negedge clock) begin
      exp_ready = reset_n && (req_write || (exp_q.size() < DEPTH));
      exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      chk("req_ready", {127'd0, req_ready}, {127'd0, exp_ready});
      chk("resp_valid", {127'd0, resp_valid}, {127'd0, exp_valid});
      if (exp_valid) chk("resp_rdata", resp_rdata, exp_q[0].data);
      chk("RW0_en", {127'd0, RW0_en}, {127'd0, req_valid && exp_ready});
      if (req_valid && exp_ready) begin
         chk("RW0_wmode", {127'd0, RW0_wmode}, {127'd0, req_write});
         chk("RW0_addr", {116'd0, RW0_addr}, {116'd0, req_addr});
         if (req_write) begin
            chk("RW0_wmask", {112'd0, RW0_wmask}, {112'd0, req_wmask});
            chk("RW0_wdata", RW0_wdata, req_wdata);
         end
      end
`ifdef ARRAY_SEQ_PERF_EN
      chk("perf_reads", {96'd0, perf_reads}, {96'd0, 32'(m_reads)});
      chk("perf_writes", {96'd0, perf_writes}, {96'd0, 32'(m_writes)});
      chk("perf_stalls", {96'd0, perf_stalls}, {96'd0, 32'(m_stalls)});
`else
      chk("perf_zero", {32'd0, perf_reads, perf_writes, perf_stalls}, 128'd0);
`endif
      if (!reset_n) begin
         exp_q.delete();
         m_reads = 0; m_writes = 0; m_stalls = 0;
      end else begin
         if (resp_ready && exp_valid) begin
            void'(exp_q.pop_front());
            n_resp++;
         end
         if (req_valid && exp_ready) begin
            if (req_write) begin
               shadow[req_addr] = merge(shadow[req_addr], req_wdata, req_wmask);
               m_writes++;
            end else begin
               exp_q.push_back('{data: shadow[req_addr], avail: cyc + 2});
               m_reads++;
            end
         end else if (req_valid) begin
            m_stalls++;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input logic v, input logic w, input logic [AW-1:0] a,
                          input logic [MW-1:0] m, input logic [DW-1:0] d);
      req_valid = v; req_write = w; req_addr = a; req_wmask = m; req_wdata = d;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] a_data;
      int acc, stalls, n0, seen;
      for (int i = 0; i < 4096; i++) begin
         shadow[i] = '0;
         env_mem[i] = '0;
      end
      m_reads = 0; m_writes = 0; m_stalls = 0;
      reset_n = 1'b0; resp_ready = 1'b0;
      set_req(1'b1, 1'b1, 12'h001, 16'hFFFF, 128'h1);
      tick(); tick();
      @(negedge clock);
      chk("rst_req_ready", {127'd0, req_ready}, 128'd0);
      chk("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
      chk("rst_RW0_en", {127'd0, RW0_en}, 128'd0);
      tick();
      reset_n = 1'b1; resp_ready = 1'b1;
      set_req(1'b0, 1'b0, 12'h000, 16'h0000, 128'h0);
      tick();

      // write then read same address, data after two cycles
      a_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      set_req(1'b1, 1'b1, 12'h005, 16'hFFFF, a_data); tick();
      set_req(1'b1, 1'b0, 12'h005, 16'h0000, 128'h0); tick();
      set_req(1'b0, 1'b0, 12'h000, 16'h0000, 128'h0);
      @(negedge clock);
      chk("r034_not_yet", {127'd0, resp_valid}, 128'd0);
      tick();
      @(negedge clock);
      chk("r034_valid", {127'd0, resp_valid}, 128'd1);
      chk("r034_data", resp_rdata, a_data);
      tick();

      // byte-masked write into zeroed location
      set_req(1'b1, 1'b1, 12'h010, 16'h0001, {4{32'hFFFF_FFFF}}); tick();
      set_req(1'b1, 1'b0, 12'h010, 16'h0000, 128'h0); tick();
      set_req(1'b0, 1'b0, 12'h000, 16'h0000, 128'h0);
      tick();
      @(negedge clock);
      chk("r035_data", resp_rdata, 128'hFF);
      tick();

      // credit stall with resp_ready low
      for (int k = 0; k < 5; k++) begin
         set_req(1'b1, 1'b1, AW'(12'h020 + k), 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});
         tick();
      end
      resp_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 5; k++) begin
         set_req(1'b1, 1'b0, AW'(12'h020 + acc), 16'h0000, 128'h0);
         @(negedge clock);
         if (req_ready) acc++;
         tick();
      end
      chk("r036_accepted", 128'(acc), 128'd3);
      set_req(1'b1, 1'b1, 12'h030, 16'hFFFF, 128'hABCD);
      @(negedge clock);
      chk("r036_write_ok", {127'd0, req_ready}, 128'd1);
      tick();
      set_req(1'b1, 1'b0, AW'(12'h020 + acc), 16'h0000, 128'h0);
      @(negedge clock);
      chk("r036_read_stall", {127'd0, req_ready}, 128'd0);
      tick();
      resp_ready = 1'b1;
      for (int k = 0; k < 20 && acc < 5; k++) begin
         set_req(1'b1, 1'b0, AW'(12'h020 + acc), 16'h0000, 128'h0);
         @(negedge clock);
         if (req_ready) acc++;
         tick();
      end
      chk("r036_all_accepted", 128'(acc), 128'd5);
      set_req(1'b0, 1'b0, 12'h000, 16'h0000, 128'h0);
      for (int k = 0; k < 6; k++) tick();

      // back-to-back reads
      n0 = n_resp; stalls = 0;
      for (int k = 0; k < 100; k++) begin
         set_req(1'b1, 1'b0, AW'($urandom_range(0, 63)), 16'h0000, 128'h0);
         @(negedge clock);
         if (!req_ready) stalls++;
         tick();
      end
      set_req(1'b0, 1'b0, 12'h000, 16'h0000, 128'h0);
      for (int k = 0; k < 5; k++) tick();
      chk("r037_no_stall", 128'(stalls), 128'd0);
      chk("r037_responses", 128'(n_resp - n0), 128'd100);

      // reset with two queued and one in flight
      resp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_req(1'b1, 1'b0, AW'(12'h020 + k), 16'h0000, 128'h0);
         tick();
      end
      set_req(1'b0, 1'b0, 12'h000, 16'h0000, 128'h0);
      @(negedge clock);
      chk("r038_queued", {127'd0, resp_valid}, 128'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1; resp_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         if (resp_valid) seen++;
         tick();
      end
      chk("r038_no_stale", 128'(seen), 128'd0);

      // randomized traffic with occasional reset
      for (int k = 0; k < 600; k++) begin
         reset_n = ($urandom_range(0, 63) != 0);
         resp_ready = ($urandom_range(0, 9) < 7);
         set_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 15)), 16'($urandom),
                 {$urandom, $urandom, $urandom, $urandom});
         tick();
      end
      reset_n = 1'b1; resp_ready = 1'b1;
      set_req(1'b0, 1'b0, 12'h000, 16'h0000, 128'h0);
      for (int k = 0; k < 5; k++) tick();

      // counter scenario: 4 writes, 6 reads, 3 stall cycles
      reset_n = 1'b0; tick(); tick();
      reset_n = 1'b1; resp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_req(1'b1, 1'b1, AW'(12'h040 + k), 16'hFFFF, 128'(k + 7));
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         set_req(1'b1, 1'b0, AW'(12'h040 + (k % 4)), 16'h0000, 128'h0);
         tick();
      end
      set_req(1'b0, 1'b0, 12'h000, 16'h0000, 128'h0);
      resp_ready = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      for (int k = 0; k < 3; k++) begin
         set_req(1'b1, 1'b0, AW'(12'h040 + k), 16'h0000, 128'h0);
         tick();
      end
      set_req(1'b0, 1'b0, 12'h000, 16'h0000, 128'h0);
      for (int k = 0; k < 4; k++) tick();
      @(negedge clock);
`ifdef ARRAY_SEQ_PERF_EN
      chk("r039_writes", {96'd0, perf_writes}, 128'd4);
      chk("r039_reads", {96'd0, perf_reads}, 128'd6);
      chk("r039_stalls", {96'd0, perf_stalls}, 128'd3);
`else
      chk("r039_writes", {96'd0, perf_writes}, 128'd0);
      chk("r039_reads", {96'd0, perf_reads}, 128'd0);
      chk("r039_stalls", {96'd0, perf_stalls}, 128'd0);
`endif
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/array_req_sequencer.md
ARRAY_REQ_SEQUENCER -- requirements
Module: array_req_sequencer

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-low.
REQ-002 Parameter ADDR_W, default 12, SHALL set the array address width.
REQ-003 Parameter DATA_W, default 128, SHALL set the data width; mask width SHALL be DATA_W/8.
REQ-004 Parameter RESP_DEPTH, default 3, SHALL set the number of read-response FIFO entries (minimum 2).
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 req_valid / req_ready  in / out  1 / 1  request handshake; transfer when both are high.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  array address.
REQ-010 req_wmask  in  DATA_W/8  byte write enables.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 resp_valid / resp_ready  out / in  1 / 1  read-response handshake.
REQ-013 resp_rdata  out  DATA_W  read data.
REQ-014 RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata  out  (1, 1, ADDR_W, DATA_W/8, DATA_W)  drive the single-port array.
REQ-015 RW0_rdata  in  DATA_W  array read data, valid exactly one cycle after a read is issued.
REQ-016 perf_reads, perf_writes, perf_stalls  out  32 each  event counters (see Configuration).

Function
REQ-017 Free credit SHALL be computed as RESP_DEPTH - fifo_count - rd_inflight.
- Writes SHALL always be accepted.
- req_ready SHALL equal req_write OR (free credit > 0), forced to 0 while reset_n is low.
REQ-018 Issue SHALL be zero-latency.
- RW0_en = req_valid & req_ready & reset_n.
- RW0_wmode = req_write.
- RW0_addr, RW0_wmask and RW0_wdata SHALL pass through combinationally.
REQ-019 rd_inflight SHALL be a 1-bit register, set on the cycle after an accepted read and cleared otherwise.
REQ-020 When rd_inflight is 1, RW0_rdata SHALL be written into the response FIFO at the end of that cycle.
- No other cycle's RW0_rdata SHALL be captured.
REQ-021 Read latency SHALL be fixed.
- A read accepted in cycle T SHALL show resp_valid=1 with its data no earlier than cycle T+2.
- Responses SHALL be returned in acceptance order.
REQ-022 resp_valid SHALL be 1 if and only if fifo_count > 0.
- resp_rdata SHALL be the head entry, registered with no combinational path from RW0_rdata.
REQ-023 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
- Read and write pointers SHALL wrap modulo RESP_DEPTH.
REQ-024 The FIFO SHALL never overflow, because the credit rule in REQ-017 guarantees a free slot for every in-flight read.
REQ-025 With RESP_DEPTH >= 3 and resp_ready held at 1, back-to-back reads SHALL sustain one accepted read per cycle.
REQ-026 While resp_ready is 0, the head entry SHALL be held stable.
- Reads SHALL stall once credit reaches 0; writes SHALL continue to be accepted.
REQ-027 A write followed by a read of the same address in the next cycle SHALL return the written data.
- Ordering is inherent because the array is single-port and requests issue in order.

Reset
REQ-028 While reset_n is low at a clock edge:
- fifo_count, both pointers and rd_inflight SHALL clear to 0.
- resp_valid and req_ready SHALL be 0, and RW0_en SHALL be 0.
- perf counters SHALL clear to 0.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight read and all queued responses.
- No response SHALL be produced for them after reset releases.
REQ-030 FIFO data storage SHALL NOT require reset.

Configuration
REQ-031 Macro ARRAY_SEQ_PERF_EN SHALL compile in the performance counters.
REQ-032 With ARRAY_SEQ_PERF_EN defined:
- perf_reads SHALL increment on each accepted read.
- perf_writes SHALL increment on each accepted write.
- perf_stalls SHALL increment on each cycle with req_valid=1 and req_ready=0.
- All three SHALL wrap modulo 2^32.
REQ-033 Without ARRAY_SEQ_PERF_EN, the ports SHALL remain present and tied to 0, and no counter flops SHALL exist.

Verification
REQ-034 Write addr 0x005, mask 0xFFFF, data A; then read 0x005 -> resp_rdata=A two cycles after the read is accepted.
REQ-035 Write mask 0x0001 with data 0x..FF to a location previously holding all zeros; read it -> only byte 0 = 0xFF.
REQ-036 Hold resp_ready=0 and issue 5 reads -> exactly 3 accepted, then req_ready=0 for reads while writes are still accepted; release resp_ready -> responses arrive in order and the remaining reads proceed.
REQ-037 100 back-to-back reads with resp_ready=1 -> req_ready stays 1 throughout and 100 in-order responses are returned.
REQ-038 Assert reset_n=0 for one cycle with 2 reads queued and 1 in flight -> resp_valid=0 afterwards and no stale response is ever delivered.
REQ-039 With ARRAY_SEQ_PERF_EN: 4 writes, 6 reads and 3 stall cycles -> perf_writes=4, perf_reads=6, perf_stalls=3; without the macro -> all three counters read 0.
